// File: rtl/liteic_master_node_read_if.sv
// AXI-Lite read-channel bundle between an upstream master and the interconnect node.
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic                  ar_valid;
    logic                  ar_ready;
    logic [31:0]           r_data;
    logic [1:0]            r_resp;
    logic                  r_valid;
    logic                  r_ready;

    modport master (
        output ar_addr, ar_valid, r_ready,
        input  ar_ready, r_data, r_resp, r_valid
    );

    modport slave (
        input  ar_addr, ar_valid, r_ready,
        output ar_ready, r_data, r_resp, r_valid
    );
endinterface

// File: rtl/liteic_master_node_read.sv
// Read-side master node of the lite interconnect: decodes one AXI-Lite read at a time
// onto a one-hot crossbar slot and returns the slot's response, or DECERR when unmapped.
module liteic_master_node_read #(
    parameter int                      NUM_SLAVE_SLOTS = 4,
    parameter int                      ARADDR_WIDTH    = 32,
    parameter int                      RDATA_WIDTH     = 34,
    parameter logic [ARADDR_WIDTH-1:0] SLV_BASE [NUM_SLAVE_SLOTS] =
        '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000},
    parameter logic [ARADDR_WIDTH-1:0] SLV_MASK [NUM_SLAVE_SLOTS] =
        '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    axi_lite_if.slave                                   mst_axil,
    output logic [ARADDR_WIDTH-1:0]                     cbar_reqst_data_o,
    output logic [NUM_SLAVE_SLOTS-1:0]                  cbar_reqst_val_o,
    input  logic [NUM_SLAVE_SLOTS-1:0]                  cbar_reqst_rdy_i,
    input  logic [NUM_SLAVE_SLOTS-1:0][RDATA_WIDTH-1:0] cbar_resp_data_i,
    input  logic [NUM_SLAVE_SLOTS-1:0]                  cbar_resp_val_i,
    output logic [NUM_SLAVE_SLOTS-1:0]                  cbar_resp_rdy_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DECERR
    } state_t;

    state_t                     state;
    logic [ARADDR_WIDTH-1:0]    addr_r;
    logic [NUM_SLAVE_SLOTS-1:0] sel_r;

    logic [NUM_SLAVE_SLOTS-1:0] dec_sel;
    logic                       dec_hit;
    logic [RDATA_WIDTH-1:0]     resp_word;
    logic                       r_valid;
    logic [31:0]                r_data;
    logic [1:0]                 r_resp;
    logic [NUM_SLAVE_SLOTS-1:0] resp_rdy;

    // Address decode: lowest matching slot wins, so overlapping regions resolve deterministically.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        dec_sel = '0;
        dec_hit = 1'b0;
        for (int i = 0; i < NUM_SLAVE_SLOTS; i++) begin
            if (!dec_hit && ((mst_axil.ar_addr & SLV_MASK[i]) == SLV_BASE[i])) begin
                dec_sel[i] = 1'b1;
                dec_hit    = 1'b1;
            end
        end
    end

    always_comb begin
        resp_word = '0;
        for (int i = 0; i < NUM_SLAVE_SLOTS; i++) begin
            resp_word = resp_word | (cbar_resp_data_i[i] & {RDATA_WIDTH{sel_r[i]}});
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments only, so every branch sees pre-edge values.
        if (rst_i) begin
            state  <= IDLE;
            addr_r <= '0;
            sel_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mst_axil.ar_valid) begin
                        addr_r <= mst_axil.ar_addr;
                        sel_r  <= dec_sel;
                        state  <= dec_hit ? REQ : DECERR;
                    end
                end
                REQ: begin
                    if (|(sel_r & cbar_reqst_rdy_i)) state <= RESP;
                end
                RESP: begin
                    if (r_valid && mst_axil.r_ready) state <= IDLE;
                end
                DECERR: begin
                    if (mst_axil.r_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response path is combinational so a slot's response reaches the master in the same cycle.
    always_comb begin
        r_valid  = 1'b0;
        r_data   = '0;
        r_resp   = '0;
        resp_rdy = '0;
        case (state)
            RESP: begin
                r_valid  = |(sel_r & cbar_resp_val_i);
                r_data   = resp_word[RDATA_WIDTH-1 -: 32];
                r_resp   = resp_word[1:0];
                resp_rdy = sel_r & {NUM_SLAVE_SLOTS{mst_axil.r_ready}};
            end
            DECERR: begin
                r_valid = 1'b1;
                r_resp  = 2'b11;
            end
            default: ;
        endcase
    end

    assign mst_axil.ar_ready = (state == IDLE);
    assign mst_axil.r_valid  = r_valid;
    assign mst_axil.r_data   = r_data;
    assign mst_axil.r_resp   = r_resp;

    assign cbar_reqst_data_o = addr_r;
    assign cbar_reqst_val_o  = (state == REQ) ? sel_r : '0;
    assign cbar_resp_rdy_o   = resp_rdy;

endmodule

// File: doc/liteic_master_node_read.md
LITEIC_MASTER_NODE_READ -- requirements
Module: liteic_master_node_read

Interface
REQ-001 SHALL have parameter NUM_SLAVE_SLOTS, default 4, number of crossbar slave slots.
REQ-002 SHALL have parameter ARADDR_WIDTH, default 32, read address width.
REQ-003 SHALL have parameter RDATA_WIDTH, default 34, crossbar response word {r_data[31:0], r_resp[1:0]}.
REQ-004 SHALL have parameter SLV_BASE [NUM_SLAVE_SLOTS], default slot i = i<<28, region base per slot.
REQ-005 SHALL have parameter SLV_MASK [NUM_SLAVE_SLOTS], default 32'hF000_0000 for all slots, region mask per slot.
REQ-006 SHALL have port clk_i, input, 1, the single clock; one clock domain, all logic on posedge clk_i.
REQ-007 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port mst_axil, axi_lite_if, -, upstream master read channel (ar_addr, ar_valid, ar_ready, r_data[31:0], r_resp[1:0], r_valid, r_ready); block is responder.
REQ-009 SHALL have port cbar_reqst_data_o, output, ARADDR_WIDTH, registered request address, common to all slots.
REQ-010 SHALL have port cbar_reqst_val_o, output, NUM_SLAVE_SLOTS, one-hot request valid.
REQ-011 SHALL have port cbar_reqst_rdy_i, input, NUM_SLAVE_SLOTS, per-slot request ready.
REQ-012 SHALL have port cbar_resp_data_i, input, RDATA_WIDTH x NUM_SLAVE_SLOTS, per-slot response word.
REQ-013 SHALL have port cbar_resp_val_i, input, NUM_SLAVE_SLOTS, per-slot response valid.
REQ-014 SHALL have port cbar_resp_rdy_o, output, NUM_SLAVE_SLOTS, one-hot response ready.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, RESP, DECERR, with one read outstanding at most.
REQ-016 In IDLE, ar_ready SHALL be 1; all other states 0.
REQ-017 On ar_valid&ar_ready, SHALL register ar_addr and the decoded one-hot slot select sel_r in the same edge.
REQ-018 Decode SHALL match slot i when (ar_addr & SLV_MASK[i]) == SLV_BASE[i]; on multiple matches lowest index wins.
REQ-019 From IDLE, SHALL go to REQ on a matching handshake, DECERR on no match; otherwise stay in IDLE.
REQ-020 In REQ, cbar_reqst_val_o SHALL equal sel_r (first asserted cycle N+1 after AR handshake at N); 0 in every other state.
REQ-021 cbar_reqst_val_o and cbar_reqst_data_o SHALL hold stable until |(sel_r & cbar_reqst_rdy_i); REQ->RESP on that edge.
REQ-022 In RESP, r_valid SHALL equal |(sel_r & cbar_resp_val_i) combinationally, {r_data, r_resp} SHALL be the selected slot's cbar_resp_data_i, and cbar_resp_rdy_o SHALL equal sel_r masked by r_ready.
REQ-023 On the RESP handshake (r_valid & r_ready), SHALL go RESP->IDLE; the next AR SHALL be accepted no earlier than the following cycle.
REQ-024 Responses or readies from unselected slots SHALL be ignored in all states.
REQ-025 In DECERR, SHALL drive r_valid=1, r_data=0, r_resp=2'b11 with no crossbar activity, holding until r_ready, then go to IDLE.
REQ-026 Outside RESP/DECERR, r_valid SHALL be 0 and cbar_resp_rdy_o SHALL be 0.
REQ-027 ar_ready==1 in IDLE SHALL not depend on ar_valid.

Reset
REQ-028 With rst_i=1 at a clock edge, SHALL enter IDLE, clear sel_r and address register to 0, giving ar_ready=1, r_valid=0, cbar_reqst_val_o=0, cbar_resp_rdy_o=0.
REQ-029 Reset mid-transaction (REQ/RESP/DECERR) SHALL abandon the transaction with no further handshake on either side.

Verification
REQ-030 AR addr 32'h2000_0010 at cycle 0, slot 2 rdy=1 at cycle 1 -> cbar_reqst_val_o=4'b0100 and data=32'h2000_0010 at cycle 1; resp 34'h0_1234_5678<<2 returns r_data=32'h1234_5678, r_resp=0.
REQ-031 Slot 1 holds rdy=0 for 5 cycles -> val_o=4'b0010 and addr stable 6 cycles; ar_ready=0 throughout.
REQ-032 Override SLV_BASE to map only slots 0..2, AR addr 32'hF000_0000 -> r_valid at cycle 1 with r_resp=2'b11, r_data=0, cbar_reqst_val_o never set.
REQ-033 r_ready held 0 for 3 cycles while slot 0 resp_val=1 -> r_valid/data stable, cbar_resp_rdy_o=0 until r_ready=1, then IDLE next cycle.
REQ-034 Slot 3 asserts resp_val spuriously while slot 0 selected -> no r_valid until slot 0 responds.
REQ-035 rst_i pulsed in RESP -> next cycle ar_ready=1, all crossbar outputs 0; subsequent read completes normally.
